// File: rtl/xbus_pkg.sv
// Xbus arbiter shared definitions: bus widths and the arbiter FSM encoding.
package xbus_pkg;

    localparam int XBUS_ADR_W  = 22;
    localparam int XBUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } xbus_state_e;

endpackage

// File: rtl/xbus_arbiter_if.sv
// Xbus pin bundle. The master modport is the arbiter side and the slave
// modport is the responder side. Address is inverted on the wire and
// acknowledge is active low.
interface xbus_arbiter_if;
    import xbus_pkg::*;

    logic                   rq_n;
    logic                   wrcyc;
    logic [XBUS_ADR_W-1:0]  adr_n;
    logic [XBUS_DATA_W-1:0] bus_out;
    logic                   bus_oe;
    logic [XBUS_DATA_W-1:0] bus_in;
    logic                   ack_n;

    modport master (output rq_n, wrcyc, adr_n, bus_out, bus_oe,
                    input  bus_in, ack_n);
    modport slave  (input  rq_n, wrcyc, adr_n, bus_out, bus_oe,
                    output bus_in, ack_n);
endinterface

// File: rtl/xbus_rr_pick.sv
// Round-robin pick: returns a one-hot winner. The search starts at the
// requester after `last`, so the previous winner has the lowest priority.
module xbus_rr_pick #(
    parameter  int NREQ = 3,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] win
);

    logic          found;
    logic [IW-1:0] idx;

    // Scan NREQ positions starting after the last winner; the first pending request wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Xbus arbiter: grants one of NREQ requesters in round-robin order and runs
// one Xbus transaction with the sequence IDLE -> REQ -> RELEASE.
// The optional no-ack timeout is compiled in with XBUS_ARB_TIMEOUT_EN.
module xbus_arbiter
    import xbus_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int TMO_CYCLES = 32
) (
    input  logic                        mclk,
    input  logic                        reset_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             req_wr,
    input  logic [NREQ*XBUS_ADR_W-1:0]  req_adr,
    input  logic [NREQ*XBUS_DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             done,
    output logic                        err,
    output logic [XBUS_DATA_W-1:0]      rdata,
    xbus_arbiter_if.master              xb
);

    localparam int IW = $clog2(NREQ);

    xbus_state_e            state_q, state_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic [NREQ-1:0]        done_q, done_d;
    logic [IW-1:0]          last_q, last_d;
    logic                   wrcyc_q, wrcyc_d;
    logic [XBUS_ADR_W-1:0]  adr_n_q, adr_n_d;
    logic [XBUS_DATA_W-1:0] bus_out_q, bus_out_d;
    logic [XBUS_DATA_W-1:0] rdata_q, rdata_d;

    logic [NREQ-1:0]        win;
    logic [IW-1:0]          win_idx;

`ifdef XBUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    // Keeps TMO_CYCLES referenced when the timeout is compiled out.
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYCLES;
`endif

    xbus_rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    // Convert the one-hot winner to an index for the pointer and the operand muxes.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) win_idx = IW'(i);
        end
    end

    // Next-state logic. Grant registers all winner operands; completion drops the grant.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        last_d    = last_q;
        wrcyc_d   = wrcyc_q;
        adr_n_d   = adr_n_q;
        bus_out_d = bus_out_q;
        rdata_d   = rdata_q;
`ifdef XBUS_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // An acknowledge still held low (stuck or late) blocks a new grant.
                if (|req && xb.ack_n) begin
                    state_d   = REQ;
                    gnt_d     = win;
                    last_d    = win_idx;
                    wrcyc_d   = req_wr[win_idx];
                    adr_n_d   = ~req_adr[int'(win_idx)*XBUS_ADR_W +: XBUS_ADR_W];
                    bus_out_d = req_wdata[int'(win_idx)*XBUS_DATA_W +: XBUS_DATA_W];
`ifdef XBUS_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            REQ: begin
                if (!xb.ack_n) begin
                    if (!wrcyc_q) rdata_d = xb.bus_in;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = RELEASE;
`ifdef XBUS_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TMO_CYCLES - 1)) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    state_d = RELEASE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
`endif
                end
            end
            RELEASE: begin
                if (xb.ack_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bus registers. Reset abandons any transaction and parks the pointer on NREQ-1.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            last_q    <= IW'(NREQ - 1);
            wrcyc_q   <= 1'b0;
            adr_n_q   <= '1;
            bus_out_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            last_q    <= last_d;
            wrcyc_q   <= wrcyc_d;
            adr_n_q   <= adr_n_d;
            bus_out_q <= bus_out_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef XBUS_ARB_TIMEOUT_EN
    // No-ack timeout counter and its error pulse.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign xb.rq_n    = (state_q != REQ);
    assign xb.bus_oe  = (state_q == REQ) && wrcyc_q;
    assign xb.wrcyc   = wrcyc_q;
    assign xb.adr_n   = adr_n_q;
    assign xb.bus_out = bus_out_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Self-checking bench for xbus_arbiter: directed scenarios, then randomized
// traffic checked against a round-robin reference model.
// The timeout scenario follows XBUS_ARB_TIMEOUT_EN.
module tb_xbus_arbiter;
    import xbus_pkg::*;

    localparam int NREQ = 3;
    localparam int TMO  = 32;

    logic                        mclk = 1'b0;
    logic                        reset_n;
    logic [NREQ-1:0]             req, req_wr;
    logic [NREQ*XBUS_ADR_W-1:0]  req_adr;
    logic [NREQ*XBUS_DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]             gnt, done;
    logic                        err;
    logic [31:0]                 rdata;

    xbus_arbiter_if xb();

    xbus_arbiter #(.NREQ(NREQ), .TMO_CYCLES(TMO)) dut (
        .mclk(mclk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
        .req_adr(req_adr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .xb(xb)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    // Observations filled in by drive_txn
    bit              obs_ok, obs_stable, obs_early_done;
    int              obs_lat;
    logic [NREQ-1:0] obs_gnt, obs_done, obs_gnt_rel, obs_done_after;
    logic [21:0]     obs_adr_n;
    logic            obs_wr, obs_oe, obs_err, obs_rqn_rel, obs_oe_rel;
    logic [31:0]     obs_bus_out, obs_rdata;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; xb.ack_n = 1'b1; xb.bus_in = '0;
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    // Responder: wait for rq_n low, hold ack off for dly cycles, ack with rd.
    task automatic drive_txn(input int dly, input logic [31:0] rd, input bit drop);
        bit seen = 0;
        obs_stable = 1; obs_early_done = 0; obs_lat = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(); obs_lat++;
            if (xb.rq_n === 1'b0) seen = 1;
        end
        obs_ok = seen;
        if (!seen) return;
        obs_gnt = gnt; obs_adr_n = xb.adr_n; obs_wr = xb.wrcyc;
        obs_bus_out = xb.bus_out; obs_oe = xb.bus_oe;
        if (drop) req = req & ~obs_gnt;
        for (int i = 0; i < dly; i++) begin
            cyc();
            if (xb.rq_n !== 1'b0 || gnt !== obs_gnt || xb.adr_n !== obs_adr_n ||
                xb.wrcyc !== obs_wr || xb.bus_out !== obs_bus_out || xb.bus_oe !== obs_oe)
                obs_stable = 0;
            if (done !== '0) obs_early_done = 1;
        end
        xb.bus_in = rd; xb.ack_n = 1'b0;
        cyc();
        obs_done = done; obs_err = err; obs_rdata = rdata;
        obs_rqn_rel = xb.rq_n; obs_gnt_rel = gnt; obs_oe_rel = xb.bus_oe;
        xb.ack_n = 1'b1;
        cyc();
        obs_done_after = done;
    endtask

    task automatic test_reset();
        req = '0; req_wr = '0; req_adr = '0; req_wdata = '0;
        xb.ack_n = 1'b1; xb.bus_in = '0;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        checks++; if (xb.rq_n !== 1'b1 || xb.wrcyc !== 1'b0 || xb.bus_oe !== 1'b0) begin
            errors++; $display("FAIL reset_ctl rq_n=%b wrcyc=%b oe=%b want 1 0 0", xb.rq_n, xb.wrcyc, xb.bus_oe); end
        checks++; if (xb.adr_n !== 22'h3FFFFF || xb.bus_out !== 32'h0) begin
            errors++; $display("FAIL reset_bus adr_n=%h bus_out=%h want 3fffff 0", xb.adr_n, xb.bus_out); end
        checks++; if (gnt !== '0 || done !== '0 || err !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL reset_out gnt=%b done=%b err=%b rdata=%h want 0", gnt, done, err, rdata); end
        cyc(2);
        reset_n = 1'b1;
    endtask

    task automatic test_read();
        logic [21:0] a;
        do_reset();
        a = 22'o17377774;
        req_adr[21:0] = a; req_wr = 3'b000; req = 3'b001;
        drive_txn(3, 32'd1, 0);
        req = '0;
        checks++; if (!obs_ok || obs_lat !== 1) begin
            errors++; $display("FAIL read_latency seen=%0d lat=%0d want 1 1", obs_ok, obs_lat); end
        checks++; if (obs_gnt !== 3'b001 || obs_adr_n !== ~a || obs_wr !== 1'b0 || obs_oe !== 1'b0) begin
            errors++; $display("FAIL read_grant gnt=%b adr_n=%o wr=%b oe=%b want 001 %o 0 0", obs_gnt, obs_adr_n, obs_wr, obs_oe, ~a); end
        checks++; if (!obs_stable || obs_early_done) begin
            errors++; $display("FAIL read_hold stable=%0d early_done=%0d want 1 0", obs_stable, obs_early_done); end
        checks++; if (obs_done !== 3'b001 || obs_err !== 1'b0 || obs_rdata !== 32'd1) begin
            errors++; $display("FAIL read_done done=%b err=%b rdata=%h want 001 0 1", obs_done, obs_err, obs_rdata); end
        checks++; if (obs_rqn_rel !== 1'b1 || obs_gnt_rel !== '0 || obs_done_after !== '0) begin
            errors++; $display("FAIL read_release rq_n=%b gnt=%b done_next=%b want 1 000 000", obs_rqn_rel, obs_gnt_rel, obs_done_after); end
    endtask

    // Follows test_read without reset: the pointer is at 0 and rdata holds 1.
    task automatic test_write();
        logic [21:0] a;
        a = 22'o17377775;
        req_adr[43:22] = a; req_wdata[63:32] = 32'o1234; req_wr = 3'b010; req = 3'b010;
        drive_txn(2, 32'hDEAD_BEEF, 0);
        req = '0;
        checks++; if (!obs_ok || obs_gnt !== 3'b010 || obs_wr !== 1'b1 || obs_oe !== 1'b1 || obs_bus_out !== 32'o1234 || obs_adr_n !== ~a) begin
            errors++; $display("FAIL write_grant gnt=%b wr=%b oe=%b data=%o adr_n=%o", obs_gnt, obs_wr, obs_oe, obs_bus_out, obs_adr_n); end
        checks++; if (!obs_stable) begin
            errors++; $display("FAIL write_hold stable=%0d want 1", obs_stable); end
        checks++; if (obs_done !== 3'b010 || obs_rdata !== 32'd1 || obs_oe_rel !== 1'b0) begin
            errors++; $display("FAIL write_done done=%b rdata=%h oe=%b want 010 1 0", obs_done, obs_rdata, obs_oe_rel); end
    endtask

    task automatic test_contention();
        do_reset();
        req_wr = '0; req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            drive_txn(1 + k % 2, 32'(k), 0);
            checks++; if (!obs_ok || obs_gnt !== 3'(1 << (k % 3)) || obs_lat !== 1) begin
                errors++; $display("FAIL contention_%0d gnt=%b lat=%0d want %b 1", k, obs_gnt, obs_lat, 3'(1 << (k % 3))); end
        end
        req = '0;
    endtask

    task automatic test_drop_req();
        bit quiet = 1;
        do_reset();
        req_wr = '0; req = 3'b100;
        drive_txn(2, 32'h55, 1);
        checks++; if (!obs_ok || obs_gnt !== 3'b100 || obs_done !== 3'b100 || obs_rdata !== 32'h55) begin
            errors++; $display("FAIL drop_req gnt=%b done=%b rdata=%h want 100 100 55", obs_gnt, obs_done, obs_rdata); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (gnt !== '0 || xb.rq_n !== 1'b1) quiet = 0;
        end
        checks++; if (!quiet) begin
            errors++; $display("FAIL drop_idle regrant after drop gnt=%b want 000", gnt); end
    endtask

    task automatic test_stuck_ack();
        bit quiet = 1;
        do_reset();
        xb.ack_n = 1'b0; req = 3'b100;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (xb.rq_n !== 1'b1 || gnt !== '0) quiet = 0;
        end
        checks++; if (!quiet) begin
            errors++; $display("FAIL stuck_ack granted while ack_n low gnt=%b rq_n=%b", gnt, xb.rq_n); end
        xb.ack_n = 1'b1;
        drive_txn(1, 32'h9, 0);
        req = '0;
        checks++; if (!obs_ok || obs_gnt !== 3'b100 || obs_lat !== 1 || obs_done !== 3'b100) begin
            errors++; $display("FAIL stuck_release gnt=%b lat=%0d done=%b want 100 1 100", obs_gnt, obs_lat, obs_done); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0, nodone = 1;
        do_reset();
        req = 3'b010;
        for (int i = 0; i < 10 && !seen; i++) begin cyc(); if (xb.rq_n === 1'b0) seen = 1; end
        cyc(2);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (!seen || xb.rq_n !== 1'b1 || gnt !== '0) begin
            errors++; $display("FAIL reset_mid seen=%0d rq_n=%b gnt=%b want 1 1 000", seen, xb.rq_n, gnt); end
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin cyc(); if (done !== '0) nodone = 0; end
        reset_n = 1'b1;
        checks++; if (!nodone) begin
            errors++; $display("FAIL reset_mid_done done pulsed during reset"); end
        drive_txn(0, 32'h1, 0);
        req = '0;
        checks++; if (!obs_ok || obs_gnt !== 3'b001) begin
            errors++; $display("FAIL reset_mid_first gnt=%b want 001", obs_gnt); end
    endtask

    task automatic test_timeout();
        bit seen = 0;
        logic [31:0] rd0;
        do_reset();
        req_wr = '0; req = 3'b001;
        for (int i = 0; i < 10 && !seen; i++) begin cyc(); if (xb.rq_n === 1'b0) seen = 1; end
        rd0 = rdata;
`ifdef XBUS_ARB_TIMEOUT_EN
        begin
            int n = 0;
            bit hit = 0;
            for (int i = 0; i < 100 && !hit; i++) begin
                cyc(); n++;
                if (done !== '0) hit = 1;
            end
            req = '0;
            checks++; if (!seen || !hit || n !== TMO || done !== 3'b001 || err !== 1'b1 || rdata !== rd0) begin
                errors++; $display("FAIL timeout n=%0d done=%b err=%b rdata=%h want %0d 001 1 %h", n, done, err, rdata, TMO, rd0); end
            cyc();
            checks++; if (done !== '0 || err !== 1'b0 || xb.rq_n !== 1'b1) begin
                errors++; $display("FAIL timeout_after done=%b err=%b rq_n=%b want 000 0 1", done, err, xb.rq_n); end
        end
`else
        begin
            int bad = 0;
            for (int i = 0; i < 1000; i++) begin
                cyc();
                if (xb.rq_n !== 1'b0 || done !== '0 || err !== 1'b0) bad++;
            end
            checks++; if (!seen || bad != 0) begin
                errors++; $display("FAIL no_timeout seen=%0d bad_cycles=%0d want 1 0", seen, bad); end
        end
`endif
        do_reset();
    endtask

    // Randomized traffic against a rotating-priority reference model.
    task automatic test_random();
        int          last_m;
        int          w;
        logic [31:0] rdata_m, rd;
        logic [21:0] adr_m [NREQ];
        logic [31:0] wd_m [NREQ];
        do_reset();
        last_m = NREQ - 1; rdata_m = '0;
        for (int r = 0; r < 40; r++) begin
            logic [NREQ-1:0] rq;
            rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_wr = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                adr_m[i] = 22'($urandom); wd_m[i] = $urandom;
                req_adr[i*22 +: 22] = adr_m[i]; req_wdata[i*32 +: 32] = wd_m[i];
            end
            w = -1;
            for (int k = 1; k <= NREQ && w < 0; k++)
                if (rq[(last_m + k) % NREQ]) w = (last_m + k) % NREQ;
            last_m = w;
            rd = $urandom;
            req = rq;
            drive_txn(int'($urandom_range(0, 4)), rd, ($urandom % 4) == 0);
            req = '0;
            if (!req_wr[w]) rdata_m = rd;
            checks++; if (!obs_ok || obs_gnt !== 3'(1 << w) || obs_adr_n !== ~adr_m[w] || obs_wr !== req_wr[w]) begin
                errors++; $display("FAIL rand_grant r=%0d req=%b gnt=%b want %b adr_n=%h wr=%b", r, rq, obs_gnt, 3'(1 << w), obs_adr_n, obs_wr); end
            checks++; if (obs_oe !== req_wr[w] || (req_wr[w] && obs_bus_out !== wd_m[w]) || !obs_stable) begin
                errors++; $display("FAIL rand_data r=%0d oe=%b bus_out=%h want %b %h stable=%0d", r, obs_oe, obs_bus_out, req_wr[w], wd_m[w], obs_stable); end
            checks++; if (obs_done !== 3'(1 << w) || obs_err !== 1'b0 || obs_rdata !== rdata_m || obs_done_after !== '0) begin
                errors++; $display("FAIL rand_done r=%0d done=%b rdata=%h want %b %h", r, obs_done, obs_rdata, 3'(1 << w), rdata_m); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_drop_req();
        test_stuck_ack();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbus_arbiter.md
XBUS_ARBITER -- requirements
Module: xbus_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of bus requesters (2..8).
REQ-002 SHALL have parameter TMO_CYCLES, default 32, mclk cycles allowed in REQ before a no-ack error.
REQ-003 SHALL have port mclk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, NREQ, per-requester transaction request, level.
REQ-006 SHALL have port req_wr, input, NREQ, per-requester direction: 1 write, 0 read.
REQ-007 SHALL have port req_adr, input, NREQ*22, per-requester true-polarity word address, requester i in bits [22i+21:22i].
REQ-008 SHALL have port req_wdata, input, NREQ*32, per-requester write data, packed like req_adr.
REQ-009 SHALL have port gnt, output, NREQ, one-hot grant, all zero when no transaction is active.
REQ-010 SHALL have port done, output, NREQ, one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port err, output, 1, one-cycle no-ack timeout pulse, coincident with done.
REQ-012 SHALL have port rdata, output, 32, read data captured on ack.
REQ-013 SHALL have port rq_n, output, 1, Xbus request, active low.
REQ-014 SHALL have port wrcyc, output, 1, Xbus write cycle.
REQ-015 SHALL have port adr_n, output, 22, inverted Xbus address.
REQ-016 SHALL have ports bus_out (output, 32), bus_oe (output, 1) and bus_in (input, 32), the split Xbus data lines.
REQ-017 SHALL have port ack_n, input, 1, Xbus acknowledge, active low.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, RELEASE.
REQ-019 IDLE: when any req is high and ack_n=1, SHALL pick the winner round-robin starting after the last winner, then register gnt, wrcyc, adr_n=~adr and bus_out, and enter REQ.
REQ-020 SHALL not leave IDLE while ack_n=0, which covers a stuck acknowledge.
REQ-021 REQ: SHALL drive rq_n=0 and bus_oe=wrcyc, with address, data and direction held stable.
REQ-022 REQ: on sampling ack_n=0, SHALL capture bus_in into rdata (reads only; rdata holds on writes), pulse done for the winner and enter RELEASE.
REQ-023 RELEASE: SHALL drive rq_n=1, bus_oe=0 and gnt=0, and return to IDLE on sampling ack_n=1.
REQ-024 Latency: req sampled high at edge N SHALL give rq_n=0 after edge N; the earliest done is the edge after ack_n is first sampled low.
REQ-025 Back-to-back: the next grant SHALL occur no earlier than one cycle after ack_n returns high.
REQ-026 SHALL ignore a requester dropping req while granted; the transaction completes and done still pulses.
REQ-027 SHALL serve requests in rotating order when several are pending; no requester waits more than NREQ-1 transactions.
REQ-028 SHALL update the last-winner pointer at grant time.
REQ-029 The timeout counter SHALL be ceil(log2(TMO_CYCLES+1)) bits wide, clear on REQ entry, and never wrap.

Reset
REQ-030 reset_n=0 SHALL immediately force rq_n=1, wrcyc=0, adr_n=all ones, bus_oe=0, bus_out=0, gnt=0, done=0, err=0, rdata=0, state IDLE, counter 0, and last winner NREQ-1 so requester 0 wins first.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no done pulse.

Configuration
REQ-032 With XBUS_ARB_TIMEOUT_EN defined, if TMO_CYCLES cycles elapse in REQ without ack, the block SHALL pulse done and err together, leave rdata unchanged, and enter RELEASE.
REQ-033 Without XBUS_ARB_TIMEOUT_EN, REQ SHALL wait indefinitely, err SHALL be tied 0, and the counter SHALL be absent.

Structure
REQ-034 Package xbus_pkg SHALL hold XBUS_ADR_W=22, XBUS_DATA_W=32 and the FSM state enum.
REQ-035 Round-robin selection SHALL live in the sub-module xbus_rr_pick (inputs req and last winner; output one-hot winner).

Verification
REQ-036 Read: req[0] with adr 17377774, responder acks 3 cycles after rq_n falls with data 1 -> adr_n=~17377774, wrcyc=0, rdata=1, done[0] for one cycle.
REQ-037 Write: req[1] write adr 17377775 data 1234 -> wrcyc=1, bus_oe=1, bus_out=1234 throughout REQ, done[1], rdata unchanged.
REQ-038 Contention: req=111 held for 6 transactions -> grant order 0,1,2,0,1,2.
REQ-039 Timeout (macro on, TMO_CYCLES=32): no ack -> done and err pulse 32 cycles after REQ entry, then IDLE; with macro off -> rq_n stays low for 1000 cycles.
REQ-040 Reset mid-REQ -> rq_n=1 and gnt=0 without waiting for an edge, no done; after release, requester 0 wins first.
REQ-041 ack_n held 0 during IDLE with req[2] pending -> no grant until ack_n=1.
